playseq_exibe_sequencia: RTL

- Sequencer for the PlaySeq preview phase.
- On request from the main control unit, walks memory addresses 0..N, shows each stored one-hot value on the LEDs for a fixed on-time, blanks for a fixed off-time, then signals completion.
- Owns the memory address and LED drive while busy. The main UC only issues iniciar/abortar and waits for fim.

---
 rtl/playseq_exibe_sequencia.sv | 136 +++++++++++++
 1 files changed

// File: rtl/playseq_exibe_sequencia.sv
// PlaySeq preview sequencer: walks addresses 0..limite, lighting each
// stored word for T_ACESO cycles with a T_APAGADO blank gap, then pulses fim.
module playseq_exibe_sequencia #(
  parameter int T_ACESO   = 1000,
  parameter int T_APAGADO = 500,
  parameter int LARGURA_T = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [3:0] ultimo_endereco,
  input  logic [3:0] dado_memoria,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       fim,
  output logic [3:0] db_estado
);

  localparam logic [3:0] OCIOSO  = 4'h0;
  localparam logic [3:0] CARREGA = 4'h1;
  localparam logic [3:0] ACESO   = 4'h2;
  localparam logic [3:0] APAGADO = 4'h3;
  localparam logic [3:0] FINAL   = 4'hF;

  localparam logic [LARGURA_T-1:0] FIM_ACESO =
    LARGURA_T'(T_ACESO - 1);
  localparam logic [LARGURA_T-1:0] FIM_APAGADO =
    LARGURA_T'(T_APAGADO - 1);

  logic [3:0]           state_q, state_d;
  logic [3:0]           endereco_q, endereco_d;
  logic [3:0]           leds_q, leds_d;
  logic [3:0]           limite_q, limite_d;
  logic [LARGURA_T-1:0] timer_q, timer_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= OCIOSO;
      endereco_q <= '0;
      leds_q     <= '0;
      limite_q   <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      endereco_q <= endereco_d;
      leds_q     <= leds_d;
      limite_q   <= limite_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    endereco_d = endereco_q;
    leds_d     = leds_q;
    limite_d   = limite_q;
    timer_d    = timer_q;
    // Cancel wins over every state except idle, where iniciar is masked.
    if (abortar && state_q != OCIOSO) begin
      state_d    = OCIOSO;
      endereco_d = '0;
      leds_d     = '0;
      timer_d    = '0;
    end else begin
      unique case (state_q)
        OCIOSO: begin
          leds_d = '0;
          if (iniciar && !abortar) begin
            limite_d   = ultimo_endereco;
            endereco_d = '0;
            timer_d    = '0;
            state_d    = CARREGA;
          end
        end
        CARREGA: begin
          leds_d  = dado_memoria;
          timer_d = '0;
          state_d = ACESO;
        end
        ACESO: begin
          if (timer_q == FIM_ACESO) begin
            leds_d  = '0;
            timer_d = '0;
            state_d = APAGADO;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        APAGADO: begin
          leds_d = '0;
          if (timer_q == FIM_APAGADO) begin
            timer_d = '0;
            if (endereco_q == limite_q) begin
              state_d = FINAL;
            end else begin
              endereco_d = endereco_q + 4'd1;
              state_d    = CARREGA;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        FINAL: begin
          leds_d     = '0;
          endereco_d = '0;
          state_d    = OCIOSO;
        end
        default: begin
          state_d    = OCIOSO;
          endereco_d = '0;
          leds_d     = '0;
          timer_d    = '0;
        end
      endcase
    end
  end

  always_comb begin
    ocupado = (state_q != OCIOSO);
    fim     = (state_q == FINAL);
    unique case (1'b1)
      state_q == OCIOSO,
      state_q == CARREGA,
      state_q == ACESO,
      state_q == APAGADO,
      state_q == FINAL: db_estado = state_q;
      default:          db_estado = 4'hE;
    endcase
  end

  assign endereco = endereco_q;
  assign leds     = leds_q;

endmodule
